execute_stage: RTL and testbench

//   Execute stage directly downstream of the 8x16 register file. Takes the two

---
 rtl/execute_stage.sv | 190 +++++++++++++++++++
 tb/tb_execute_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage sitting directly behind the 8x16 register file.
// Single-cycle ALU ops retire one cycle after issue and can issue every cycle.
// MUL is a 16-step shift-add sequence that holds off new issues until it retires.
// The write-back bus feeds the register file write port.

module execute_stage #(
  parameter int WIDTH = 16,
  parameter int RADDR = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [RADDR-1:0] dst,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             wb_valid,
  output logic [RADDR-1:0] wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_zero,
  output logic             wb_carry,
  output logic             busy
);

  // One multiply step per operand bit, so the step counter indexes A.
  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_lat_q, a_lat_d;
  logic [WIDTH-1:0] b_lat_q, b_lat_d;
  logic [RADDR-1:0] rd_lat_q, rd_lat_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RADDR-1:0] wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             wb_zero_q, wb_zero_d;
  logic             wb_carry_q, wb_carry_d;
  logic             busy_q, busy_d;

  logic             issue;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] acc_step;

  // Ready is withheld while reset is low and for the whole multiply sequence.
  assign in_ready = (state_q == S_IDLE) & reset;
  assign issue    = in_valid & in_ready;

  // Single-cycle ALU: result and carry/borrow for the non-multiply opcodes.
  always_comb begin
    sum_ext   = {1'b0, src_a} + {1'b0, src_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = src_a - src_b;
        alu_carry = (src_a < src_b);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SHL:  alu_res = src_a << src_b[CNTW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Next accumulator value for the current multiply step (adds shifted B when A's bit is set).
  always_comb begin
    acc_step = acc_q;
    if (a_lat_q[cnt_q]) begin
      acc_step = acc_q + (b_lat_q << cnt_q);
    end
  end

  // Sequencer: issue decode, multiply stepping and write-back bus next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_lat_d    = a_lat_q;
    b_lat_d    = b_lat_q;
    rd_lat_d   = rd_lat_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_zero_d  = wb_zero_q;
    wb_carry_d = wb_carry_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            a_lat_d  = src_a;
            b_lat_d  = src_b;
            rd_lat_d = dst;
            busy_d   = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = dst;
            wb_data_d  = alu_res;
            wb_zero_d  = (alu_res == '0);
            wb_carry_d = alu_carry;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          wb_data_d  = acc_step;
          wb_zero_d  = (acc_step == '0);
          wb_carry_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      a_lat_q    <= '0;
      b_lat_q    <= '0;
      rd_lat_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      wb_carry_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_lat_q    <= a_lat_d;
      b_lat_q    <= b_lat_d;
      rd_lat_q   <= rd_lat_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_zero_q  <= wb_zero_d;
      wb_carry_q <= wb_carry_d;
      busy_q     <= busy_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_zero  = wb_zero_q;
  assign wb_carry = wb_carry_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: reset, ALU ops, back-to-back issue,
// multiply sequencing, reset mid-multiply and a register-file write/read loop.

module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [2:0]  dst;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_zero;
  logic        wb_carry;
  logic        busy;

  int tests_run;
  int tests_failed;

  logic [15:0] regs [8];

  execute_stage #(.WIDTH(16), .RADDR(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dst      (dst),
    .src_a    (src_a),
    .src_b    (src_b),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_zero  (wb_zero),
    .wb_carry (wb_carry),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: the write-back bus is its write port.
  always @(negedge clk) begin
    if (wb_valid) regs[wb_rd] = wb_data;
  end

  // Waits for a write-back pulse, counting edges; gives up after a fixed budget.
  task automatic wait_wb(output int cycles, output bit seen, output bit busy_ok);
    cycles  = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cycles < 40) begin
      if (cycles == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (wb_valid) seen = 1'b1;
      else if (!busy || in_ready) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; op = 3'd0; dst = 3'd0; src_a = 16'h0; src_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wb_valid got %b want 0", wb_valid); end
    tests_run++; if (wb_rd !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_wb_rd got %0d want 0", wb_rd); end
    tests_run++; if (wb_data !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_wb_data got %h want 0000", wb_data); end
    tests_run++; if (wb_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wb_zero got %b want 0", wb_zero); end
    tests_run++; if (wb_carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wb_carry got %b want 0", wb_carry); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub;
    in_valid = 1'b1; op = 3'b000; dst = 3'd3; src_a = 16'hFFFF; src_b = 16'h0001;
    @(posedge clk); #1;
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_valid got %b want 1", wb_valid); end
    tests_run++; if (wb_rd !== 3'd3) begin tests_failed++; $display("[TB] FAIL add_rd got %0d want 3", wb_rd); end
    tests_run++; if (wb_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL add_data got %h want 0000", wb_data); end
    tests_run++; if (wb_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_zero got %b want 1", wb_zero); end
    tests_run++; if (wb_carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_carry got %b want 1", wb_carry); end
    op = 3'b001; dst = 3'd4; src_a = 16'd3; src_b = 16'd5;
    @(posedge clk); #1;
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_valid got %b want 1", wb_valid); end
    tests_run++; if (wb_data !== 16'hFFFE) begin tests_failed++; $display("[TB] FAIL sub_data got %h want fffe", wb_data); end
    tests_run++; if (wb_carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_borrow got %b want 1", wb_carry); end
    tests_run++; if (wb_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL sub_zero got %b want 0", wb_zero); end
    op = 3'b000; src_a = 16'd10; src_b = 16'd20;
    @(posedge clk); #1;
    tests_run++; if (wb_carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_nocarry got %b want 0", wb_carry); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_valid got %b want 0", wb_valid); end
    tests_run++; if (wb_data !== 16'd30) begin tests_failed++; $display("[TB] FAIL hold_data got %h want 001e", wb_data); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [5];
    logic [15:0] exp [5];
    ops[0] = 3'b010; exp[0] = 16'h0002;
    ops[1] = 3'b011; exp[1] = 16'h8003;
    ops[2] = 3'b100; exp[2] = 16'h8001;
    ops[3] = 3'b101; exp[3] = 16'h0001;
    ops[4] = 3'b110; exp[4] = 16'h000C;
    src_a = 16'h8003; src_b = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = ops[i]; dst = 3'(i + 1);
      @(posedge clk); #1;
      tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, wb_valid); end
      tests_run++; if (wb_data !== exp[i]) begin tests_failed++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, wb_data, exp[i]); end
      tests_run++; if (wb_rd !== 3'(i + 1)) begin tests_failed++; $display("[TB] FAIL b2b_rd[%0d] got %0d want %0d", i, wb_rd, i + 1); end
    end
    in_valid = 1'b0;
    src_a = 16'h0001; src_b = 16'h0014;
    in_valid = 1'b1; op = 3'b110; dst = 3'd0;
    @(posedge clk); #1;
    tests_run++; if (wb_data !== 16'h0010) begin tests_failed++; $display("[TB] FAIL shl_b_upper got %h want 0010", wb_data); end
    src_a = 16'h0005; src_b = 16'hFFFF; op = 3'b101;
    @(posedge clk); #1;
    tests_run++; if (wb_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL slt_false got %h want 0000", wb_data); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int cycles;
    bit seen;
    bit busy_ok;
    in_valid = 1'b1; op = 3'b111; dst = 3'd5; src_a = 16'd7; src_b = 16'd9;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_busy got %b want 1", busy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_in_ready got %b want 0", in_ready); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_early_valid got %b want 0", wb_valid); end
    op = 3'b000; dst = 3'd6; src_a = 16'd1; src_b = 16'd1;
    wait_wb(cycles, seen, busy_ok);
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_timeout got %b want 1", seen); end
    tests_run++; if (cycles != 16) begin tests_failed++; $display("[TB] FAIL mul_latency got %0d want 16", cycles); end
    tests_run++; if (busy_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_busy_hold got %b want 1", busy_ok); end
    tests_run++; if (wb_data !== 16'd63) begin tests_failed++; $display("[TB] FAIL mul_data got %h want 003f", wb_data); end
    tests_run++; if (wb_rd !== 3'd5) begin tests_failed++; $display("[TB] FAIL mul_rd got %0d want 5", wb_rd); end
    tests_run++; if (wb_carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_carry got %b want 0", wb_carry); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_done_busy got %b want 0", busy); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_done_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_ignored_issue got %b want 0", wb_valid); end
    in_valid = 1'b1; op = 3'b111; dst = 3'd7; src_a = 16'd300; src_b = 16'd300;
    @(posedge clk); #1;
    wait_wb(cycles, seen, busy_ok);
    tests_run++; if (cycles != 16) begin tests_failed++; $display("[TB] FAIL mul2_latency got %0d want 16", cycles); end
    tests_run++; if (wb_data !== 16'h5F90) begin tests_failed++; $display("[TB] FAIL mul2_data got %h want 5f90", wb_data); end
    tests_run++; if (wb_rd !== 3'd7) begin tests_failed++; $display("[TB] FAIL mul2_rd got %0d want 7", wb_rd); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    bit stray;
    in_valid = 1'b1; op = 3'b111; dst = 3'd4; src_a = 16'd2; src_b = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_in_ready got %b want 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wb_valid) stray = 1'b1;
    end
    tests_run++; if (stray !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_stray_wb got %b want 0", stray); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_idle_ready got %b want 1", in_ready); end
    in_valid = 1'b1; op = 3'b000; dst = 3'd2; src_a = 16'd1; src_b = 16'd1;
    @(posedge clk); #1;
    tests_run++; if (wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_abort_valid got %b want 1", wb_valid); end
    tests_run++; if (wb_data !== 16'd2) begin tests_failed++; $display("[TB] FAIL post_abort_data got %h want 0002", wb_data); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_regfile_loop;
    logic [15:0] expv;
    for (int r = 0; r < 8; r++) regs[r] = 16'h0;
    for (int r = 1; r < 8; r++) begin
      in_valid = 1'b1; op = 3'b000; dst = 3'(r);
      src_a = 16'(r * 16'h0111); src_b = 16'h1000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int r = 1; r < 8; r++) begin
      expv = 16'(r * 16'h0111) + 16'h1000;
      tests_run++; if (regs[r] !== expv) begin tests_failed++; $display("[TB] FAIL rf_write[%0d] got %h want %h", r, regs[r], expv); end
    end
    for (int r = 1; r < 8; r++) begin
      expv = 16'(r * 16'h0111) + 16'h1000;
      in_valid = 1'b1; op = 3'b011; dst = 3'(r); src_a = regs[r]; src_b = 16'h0;
      @(posedge clk); #1;
      tests_run++; if (wb_data !== expv) begin tests_failed++; $display("[TB] FAIL rf_read[%0d] got %h want %h", r, wb_data, expv); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_regfile_loop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
